// File: rtl/two_reg_fifo.sv
// Two-entry first-word-fall-through FIFO built from two registers.
// The head entry drives the read data directly, so that data appears with zero latency.
module two_reg_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iWrEn,
  input  logic [WIDTH-1:0] iWrDat,
  input  logic             iRdEn,
  output logic             oFul,
  output logic             oEmpty,
  output logic [1:0]       oDatVld,
  output logic [WIDTH-1:0] oRdDat
);

  logic [WIDTH-1:0] entry0;
  logic [WIDTH-1:0] entry1;
  logic             vld0;
  logic             vld1;
  logic             wr_acc;
  logic             rd_acc;

  assign oFul    = vld0 & vld1;
  assign oEmpty  = ~vld0;
  assign oDatVld = {vld1, vld0};
  assign oRdDat  = entry0;

  // The full flag gates writes, so a read and a write are accepted together only at count 1.
  assign wr_acc = iWrEn & ~oFul;
  assign rd_acc = iRdEn & ~oEmpty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the data registers are reset as well as the flags, so that read data is a known zero while the FIFO is empty after reset.
      entry0 <= '0;
      entry1 <= '0;
      vld0   <= 1'b0;
      vld1   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let entry0 take the old entry1 value in the same edge that clears vld1.
      unique case ({wr_acc, rd_acc})
        2'b10: begin
          if (!vld0) begin
            entry0 <= iWrDat;
            vld0   <= 1'b1;
          end else begin
            entry1 <= iWrDat;
            vld1   <= 1'b1;
          end
        end
        2'b01: begin
          if (vld1) begin
            entry0 <= entry1;
            vld1   <= 1'b0;
          end else begin
            vld0 <= 1'b0;
          end
        end
        2'b11: entry0 <= iWrDat;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_two_reg_fifo.sv
// Self-checking bench for two_reg_fifo. A queue scoreboard holds the expected contents:
// an accepted write pushes its data, and an accepted read pops the value the head must show.
module tb_two_reg_fifo;

  logic       clk;
  logic       rst;
  logic       iWrEn;
  logic [7:0] iWrDat;
  logic       iRdEn;
  logic       oFul;
  logic       oEmpty;
  logic [1:0] oDatVld;
  logic [7:0] oRdDat;

  int n_tests;
  int n_fail;
  logic [7:0] sb[$];

  two_reg_fifo #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .iWrEn  (iWrEn),
    .iWrDat (iWrDat),
    .iRdEn  (iRdEn),
    .oFul   (oFul),
    .oEmpty (oEmpty),
    .oDatVld(oDatVld),
    .oRdDat (oRdDat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare the flags, and the head data when an entry is present, against the scoreboard occupancy.
  task automatic check_status();
    logic [1:0] exp_vld;
    exp_vld = (sb.size() == 0) ? 2'b00 : (sb.size() == 1) ? 2'b01 : 2'b11;
    check("vld",   32'(oDatVld), 32'(exp_vld));
    check("empty", 32'(oEmpty),  32'(sb.size() == 0));
    check("ful",   32'(oFul),    32'(sb.size() == 2));
    if (sb.size() > 0) check("head", 32'(oRdDat), 32'(sb[0]));
  endtask

  task automatic cycle(input bit wr, input logic [7:0] d, input bit rd);
    bit wa;
    bit ra;
    wa = wr && (sb.size() < 2);
    ra = rd && (sb.size() > 0);
    if (ra) check("rd_dat", 32'(oRdDat), 32'(sb.pop_front()));
    if (wa) sb.push_back(d);
    iWrEn  = wr;
    iWrDat = d;
    iRdEn  = rd;
    @(posedge clk);
    #1;
    iWrEn = 1'b0;
    iRdEn = 1'b0;
    check_status();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    iWrEn   = 1'b0;
    iWrDat  = 8'h00;
    iRdEn   = 1'b0;

    // Reset values are checked before the first clock edge.
    #3;
    check("rst_vld",   32'(oDatVld), 32'(2'b00));
    check("rst_empty", 32'(oEmpty),  32'(1'b1));
    check("rst_ful",   32'(oFul),    32'(1'b0));
    check("rst_dat",   32'(oRdDat),  32'(8'h00));
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle(1'b0, 8'h00, 1'b0);
    check("idle_dat", 32'(oRdDat), 32'(8'h00));

    // Fill, then overflow. 0x77 must be dropped.
    cycle(1'b1, 8'hA5, 1'b0);
    cycle(1'b1, 8'h3C, 1'b0);
    cycle(1'b1, 8'h77, 1'b0);
    check("ovf_head", 32'(oRdDat), 32'(8'hA5));

    // Drain, then underflow. The head data holds after the last read.
    cycle(1'b0, 8'h00, 1'b1);
    check("drain_head", 32'(oRdDat), 32'(8'h3C));
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    check("hold_dat", 32'(oRdDat), 32'(8'h3C));

    // Single write, then a read.
    cycle(1'b1, 8'h10, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);

    // Simultaneous read and write at count 1, then at count 2.
    cycle(1'b1, 8'h10, 1'b0);
    cycle(1'b1, 8'h11, 1'b1);
    check("rw1_head", 32'(oRdDat), 32'(8'h11));
    cycle(1'b1, 8'h22, 1'b0);
    cycle(1'b1, 8'h33, 1'b1);
    check("rw2_head", 32'(oRdDat), 32'(8'h22));

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset from full, asserted between clock edges.
    while (sb.size() > 0) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'hC3, 1'b0);
    cycle(1'b1, 8'h5E, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_vld",   32'(oDatVld), 32'(2'b00));
    check("arst_empty", 32'(oEmpty),  32'(1'b1));
    check("arst_ful",   32'(oFul),    32'(1'b0));
    check("arst_dat",   32'(oRdDat),  32'(8'h00));
    sb.delete();
    #1;
    rst = 1'b0;

    // A write is accepted at the first edge after reset is released.
    cycle(1'b1, 8'h5A, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
